seq_slice_adder: RTL
====================

// Module: seq_slice_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor. Each cycle one SLICE-bit slice goes through
//  a ripple adder built from full-adder cells, LSB slice first, with the carry
//  registered between slices. It is the parametrised successor of the one-bit
//  half/full adder cells. It is the arithmetic unit the lab datapath's ALU calls
//  through a start/done handshake, and it trades latency for a small adder.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 2
//  SLICE  4   bits added per cycle; WIDTH % SLICE == 0 is required; NS = WIDTH/SLICE
// PORTS
//  clk    in   1      single clock, rising-edge
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; sampled at a rising edge; accepted only in IDLE or DONE
//  a      in   WIDTH  operand A; captured when start is accepted
//  b      in   WIDTH  operand B; captured when start is accepted
//  cin    in   1      carry-in; used only when sub=0; captured when start is accepted
//  sub    in   1      0: a+b+cin; 1: a-b (a + ~b + 1), cin ignored; captured when start is accepted
//  busy   out  1      1 while in RUN
//  done   out  1      one-cycle pulse: sum/cout/ovf are final
//  sum    out  WIDTH  result; held stable from done until the next accepted start
//  cout   out  1      carry out of the MSB (for sub=1: 1 means no borrow)
//  ovf    out  1      signed overflow = carry into the MSB XOR carry out of the MSB
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; slice counter, carry register, internal
//    operand registers, busy, done, sum, cout and ovf are all set to 0.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: start=1 -> capture a, b (b inverted if sub=1) and carry = sub ? 1 : cin;
//          cnt=0; go to RUN.
//    RUN:  busy=1. Each edge adds slice cnt (bits cnt*SLICE +: SLICE) plus the carry
//          register. The slice result is written into sum at that position, the carry
//          register updates, and cnt increments. At the edge that processes slice NS-1,
//          latch cout and ovf and go to DONE. start is ignored in RUN. Inputs a, b,
//          cin and sub may change freely and have no effect.
//    DONE: done=1 for exactly this cycle, busy=0. start=1 -> accept as in IDLE, go to
//          RUN (back-to-back op, no idle cycle); otherwise go to IDLE.
//  - Latency: start is sampled at edge E0 and done is high in the cycle after edge
//    E_NS. This gives NS cycles from request to result. SLICE=WIDTH gives a 1-cycle
//    op. Throughput is one op per NS+1 cycles.
//  - ovf uses the carry into bit WIDTH-1, taken inside the top slice. This matches
//    two's-complement overflow for both add and sub.
//  - sum bits are written slice by slice during RUN; only the value shown while
//    done=1 (or later) is valid. After the DONE cycle, sum/cout/ovf hold in IDLE.
//  - Wrap-around: the result is modulo 2^WIDTH. The carry past the MSB appears only
//    on cout, never in sum.
//  - Reset during RUN aborts the op immediately. done never pulses for the aborted
//    op, and the first start after reset release is accepted normally.
//  - cnt width is clog2(NS) with a minimum of 1 bit; with NS=1 the FSM goes
//    IDLE->RUN->DONE.
// TESTING (WIDTH=16, SLICE=4 unless stated)
//  1 a=FFFF b=0001 cin=0 sub=0 -> sum=0000 cout=1 ovf=0; done exactly 4 cycles after start
//  2 a=7FFF b=0001 sub=0 -> sum=8000 cout=0 ovf=1; a=1234 b=4321 cin=1 -> sum=5556 cout=0 ovf=0
//  3 sub=1: a=0005 b=0007 -> sum=FFFE cout=0 ovf=0; a=8000 b=0001 -> sum=7FFF cout=1 ovf=1
//  4 start pulsed in RUN with different a/b -> ignored, first result unchanged; start in
//    DONE -> next op runs back-to-back, second done 5 cycles after first
//  5 rst_n=0 asserted mid-RUN (after 2 slices) -> busy/done/sum/cout/ovf=0 immediately,
//    no done pulse; a new op after release gives a correct result
//  6 regress SLICE=1 (16-cycle latency) and SLICE=16 (1-cycle latency) against a
//    reference model on 10k random a/b/cin/sub; sum, cout and ovf must match

Source files
------------

// File: rtl/seq_slice_adder.sv
// ---------------------------------------------------------------------------
// seq_slice_adder
//   Multi-cycle WIDTH-bit adder/subtractor. One SLICE-bit slice is added per
//   clock through a small ripple chain of full-adder cells, LSB slice first,
//   with the carry held in a register between slices. Trades latency
//   (NS = WIDTH/SLICE cycles) for a narrow adder. WIDTH must be >= 2 and a
//   multiple of SLICE.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, accepted only in IDLE or DONE
//   a, b   in   WIDTH  operands, captured when start is accepted
//   cin    in   1      carry-in for add (ignored for subtract)
//   sub    in   1      0: a+b+cin, 1: a-b
//   busy   out  1      high while slices are being processed
//   done   out  1      one-cycle pulse, sum/cout/ovf final
//   sum    out  WIDTH  result, held until the next accepted start
//   cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  1      signed overflow
// ---------------------------------------------------------------------------
module seq_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic [SLICE-1:0] sa_s;
  logic [SLICE-1:0] sb_s;
  logic [SLICE-1:0] ss_s;
  logic [SLICE:0]   c_s;
  logic [WIDTH-1:0] sum_d;

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple adder over the current slice and merge of its result into sum.
  always_comb begin
    sa_s   = {SLICE{1'b0}};
    sb_s   = {SLICE{1'b0}};
    ss_s   = {SLICE{1'b0}};
    c_s    = {(SLICE+1){1'b0}};
    sum_d  = sum_q;
    c_s[0] = carry_q;
    for (int k = 0; k < SLICE; k++) begin
      sa_s[k] = a_q[IW'(int'(cnt_q) * SLICE + k)];
      sb_s[k] = b_q[IW'(int'(cnt_q) * SLICE + k)];
      {c_s[k+1], ss_s[k]} = full_add(sa_s[k], sb_s[k], c_s[k]);
    end
    for (int k = 0; k < SLICE; k++) begin
      sum_d[IW'(int'(cnt_q) * SLICE + k)] = ss_s[k];
    end
  end

  // Control FSM plus operand, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert b here, seed carry with 1.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= c_s[SLICE];
          if (cnt_q == LAST) begin
            // Top slice: carry into the MSB is c_s[SLICE-1].
            cout_q  <= c_s[SLICE];
            ovf_q   <= c_s[SLICE] ^ c_s[SLICE-1];
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
